wb_sram_responder: RTL and testbench
====================================

Name: wb_sram_responder

Overview:
Wishbone slave-side responder: a byte-enabled, single-port synchronous SRAM target that sits on any slave port of the wb interconnects (s0..sN).
Supports classic single cycles and registered-feedback incrementing bursts (CTI=010) with linear and wrap-4/8/16 BTE.
Responds with ERR for addresses outside its window.

Parameters:
WB_ADDR_WIDTH, 32, bus address width (byte address)
WB_DATA_WIDTH, 32, bus data width; multiple of 8
MEM_ADDR_BITS, 10, log2 of memory depth in words
BASE, 'h0, window base; aligned to the window size (DATA_WIDTH/8 << MEM_ADDR_BITS)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
ADR  input  WB_ADDR_WIDTH  byte address
DAT_W  input  WB_DATA_WIDTH  write data
SEL  input  WB_DATA_WIDTH/8  byte lane enables
CYC  input  1  cycle valid
STB  input  1  strobe
WE  input  1  write enable
CTI  input  3  cycle type: 000 classic, 010 incr burst, 111 end of burst
BTE  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
DAT_R  output  WB_DATA_WIDTH  read data
ACK  output  1  transfer acknowledge
ERR  output  1  decode error

Behaviour:
- Reset is asynchronous, active-high. On reset: state=IDLE, ACK=0, ERR=0, DAT_R=0, burst address=0. The reset applies mid-transfer with no write committed after assertion. Memory contents are not reset.
- Word index is ADR[ADDR_LSB+MEM_ADDR_BITS-1:ADDR_LSB], with ADDR_LSB=$clog2(WB_DATA_WIDTH/8).
- An address hits when the bits of ADR above the window equal the same bits of BASE.
- States: IDLE, CLASSIC, BURST, ERROR.
- IDLE:
  - On CYC&STB with a miss: go to ERROR.
  - On CYC&STB with a hit: latch the word index into baddr and issue a RAM read of that index. If CTI==010, go to BURST; otherwise go to CLASSIC.
- CLASSIC:
  - ACK=1 for exactly one cycle.
  - If WE, write DAT_W under SEL to baddr in this cycle.
  - DAT_R holds the word read in the IDLE cycle (latency 1). Next state IDLE.
  - Throughput is one transfer per 2 cycles.
- ERROR: ERR=1 for one cycle, ACK=0, no memory access, DAT_R=0. Next state IDLE.
- BURST:
  - ACK = CYC & STB. This is a combinational gate of the registered state.
  - Beat completes when ACK=1. On completion:
    - If WE, write DAT_W/SEL at baddr.
    - If CTI==010, baddr <= next(baddr), issue a RAM read of next(baddr), and stay in BURST (one beat per cycle).
    - If CTI!=010, the beat is last; go to IDLE.
  - STB=0 with CYC=1: wait state; no advance, no write, DAT_R held.
  - CYC=0: abort to IDLE; no write that cycle.
- next(a), with low bits incremented modulo and upper bits held:
  - linear: (a+1) mod depth
  - wrap4: low 2 bits incremented
  - wrap8: low 3 bits incremented
  - wrap16: low 4 bits incremented
- A linear burst past the top of memory wraps to word 0 with no ERR.
- Read-during-write in a burst cannot collide: each beat reads the next address while writing the current one.
- ACK and ERR are never both 1.
- DAT_R is 0 when neither ACK nor ERR is asserted.

Decomposition:
- Shared package wb_pkg:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
  - BTE constants: BTE_LINEAR/WRAP4/WRAP8/WRAP16
  - responder state enum
  - function wb_burst_next(addr, bte)
- Sub-module wb_sram_responder_ram: single-port sync RAM, byte write enables, one read port registered, WB_DATA_WIDTH x 2**MEM_ADDR_BITS.

Test Plan:
- Classic write then read, 32-bit, BASE=0: write ADR=0x10, DAT_W=0xDEADBEEF, SEL=4'b1111 → ACK one cycle after STB; a read of 0x10 then returns 0xDEADBEEF with ACK at latency 1.
- Byte lanes: write 0x11223344 to 0x20, then write SEL=4'b0010 DAT_W=0x0000AA00 → read 0x20 returns 0x1122AA44.
- Linear burst: write 0..3 to 0x40.. with CTI 010,010,010,111 → four consecutive ACK cycles, then ACK=0. Read burst of 4 from 0x40 returns 0,1,2,3 on back-to-back ACKs.
- Wrap4 read burst starting 0x48 (word 2) with BTE=01 → data from words 2,3,0,1.
- Decode error: ADR=0x1000 (depth 1024 words = 0x1000 bytes) → ERR=1 for one cycle, ACK=0, memory unchanged.
- Wait state and abort: in a burst, drop STB 2 cycles → ACK=0 and baddr holds. Drop CYC mid-burst → IDLE, no write. Assert rst during CLASSIC → ACK/ERR/DAT_R=0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle/burst type codes, responder states,
// and the burst address sequencing helper.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC,
    ST_BURST,
    ST_ERROR
  } resp_state_t;

  // Next word address of a burst. Linear increments the whole value (the
  // caller truncates to the memory depth); wrap modes increment only the
  // low bits and keep the upper bits fixed.
  function automatic logic [31:0] wb_burst_next(input logic [31:0] addr,
                                                input logic [1:0]  bte);
    logic [31:0] n;
    n = addr;
    case (bte)
      BTE_LINEAR: n = addr + 32'd1;
      BTE_WRAP4:  n[1:0] = addr[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = addr[2:0] + 3'd1;
      default:    n[3:0] = addr[3:0] + 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_sram_responder_ram.sv
// Synchronous RAM with byte write enables, an independent write address
// and one registered read port (read and write may target different words
// in the same cycle).
module wb_sram_responder_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic [ADDR_BITS-1:0]    i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [ADDR_BITS-1:0]    i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane masked write
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < LANES; b++) begin
      if (i_we && i_sel[b]) begin
        r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read, held while no new read is issued
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone SRAM slave: classic cycles, registered-feedback incrementing
// bursts with linear/wrap sequencing, and ERR for out-of-window addresses.
module wb_sram_responder
  import wb_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int unsigned ADDR_LSB = $clog2(WB_DATA_WIDTH / 8);
  localparam int unsigned WIN_BITS = ADDR_LSB + MEM_ADDR_BITS;

  resp_state_t              r_state;
  resp_state_t              w_next_state;
  logic [MEM_ADDR_BITS-1:0] r_baddr;
  logic [MEM_ADDR_BITS-1:0] w_baddr_d;
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic [MEM_ADDR_BITS-1:0] w_burst_next;
  logic [MEM_ADDR_BITS-1:0] w_raddr;
  logic [WB_DATA_WIDTH-1:0] w_rdata;
  logic                     w_hit;
  logic                     w_re;
  logic                     w_we;
  logic                     w_ack;
  logic                     w_err;
  logic                     w_unused_adr;

  assign w_idx        = ADR[WIN_BITS-1:ADDR_LSB];
  assign w_hit        = (ADR[WB_ADDR_WIDTH-1:WIN_BITS] == BASE[WB_ADDR_WIDTH-1:WIN_BITS]);
  assign w_burst_next = MEM_ADDR_BITS'(wb_burst_next(32'(r_baddr), BTE));
  assign w_unused_adr = ^ADR[ADDR_LSB-1:0];

  // State and burst address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baddr <= '0;
    end else begin
      r_state <= w_next_state;
      r_baddr <= w_baddr_d;
    end
  end

  // Next state, handshake outputs and RAM control
  always_comb begin
    w_next_state = r_state;
    w_baddr_d    = r_baddr;
    w_raddr      = r_baddr;
    w_re         = 1'b0;
    w_we         = 1'b0;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CYC && STB) begin
          if (!w_hit) begin
            w_next_state = ST_ERROR;
          end else begin
            w_baddr_d    = w_idx;
            w_raddr      = w_idx;
            w_re         = 1'b1;
            w_next_state = (CTI == CTI_INCR) ? ST_BURST : ST_CLASSIC;
          end
        end
      end
      ST_CLASSIC: begin
        w_ack        = 1'b1;
        w_we         = WE;
        w_next_state = ST_IDLE;
      end
      ST_ERROR: begin
        w_err        = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_BURST: begin
        if (!CYC) begin
          w_next_state = ST_IDLE;
        end else if (STB) begin
          w_ack = 1'b1;
          w_we  = WE;
          // Prefetch the following beat while the current one is written,
          // so read and write addresses never coincide.
          if (CTI == CTI_INCR) begin
            w_baddr_d = w_burst_next;
            w_raddr   = w_burst_next;
            w_re      = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  wb_sram_responder_ram #(
    .DATA_WIDTH (WB_DATA_WIDTH),
    .ADDR_BITS  (MEM_ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_sel   (SEL),
    .i_waddr (r_baddr),
    .i_wdata (DAT_W),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign ACK   = w_ack;
  assign ERR   = w_err;
  assign DAT_R = w_ack ? w_rdata : '0;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder: classic, byte lanes, bursts,
// wrap sequencing, decode error, wait state, abort and mid-cycle reset.
module tb_wb_sram_responder;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ADR;
  logic [31:0] DAT_W;
  logic [3:0]  SEL;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic [31:0] DAT_R;
  logic        ACK;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_sram_responder #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .MEM_ADDR_BITS (10),
    .BASE          (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ADR   (ADR),
    .DAT_W (DAT_W),
    .SEL   (SEL),
    .CYC   (CYC),
    .STB   (STB),
    .WE    (WE),
    .CTI   (CTI),
    .BTE   (BTE),
    .DAT_R (DAT_R),
    .ACK   (ACK),
    .ERR   (ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI = CTI_CLASSIC;
    BTE = BTE_LINEAR; SEL = 4'h0; DAT_W = 32'h0; ADR = 32'h0;
  endtask

  task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_rd, input string tag);
    ADR = adr; WE = we; DAT_W = dat; SEL = sel; CTI = CTI_CLASSIC; CYC = 1'b1; STB = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_idle"}, {31'b0, ACK}, 32'd0);
    step();
    @(negedge clk);
    chk({tag, "_ack"}, {31'b0, ACK}, 32'd1);
    chk({tag, "_err"}, {31'b0, ERR}, 32'd0);
    if (!we) chk({tag, "_data"}, DAT_R, exp_rd);
    step();
    idle_bus();
    @(negedge clk);
    chk({tag, "_ack_after"}, {31'b0, ACK}, 32'd0);
    step();
  endtask

  task automatic burst(input logic [31:0] adr, input logic [1:0] bte, input logic we,
                       input int n, input logic [31:0] d [4], input string tag);
    ADR = adr; WE = we; BTE = bte; CTI = CTI_INCR; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    DAT_W = 32'h0;
    step();
    for (int i = 0; i < n; i++) begin
      DAT_W = d[i];
      CTI   = (i == n - 1) ? CTI_EOB : CTI_INCR;
      @(negedge clk);
      chk($sformatf("%s_ack%0d", tag, i), {31'b0, ACK}, 32'd1);
      chk($sformatf("%s_err%0d", tag, i), {31'b0, ERR}, 32'd0);
      if (!we) chk($sformatf("%s_data%0d", tag, i), DAT_R, d[i]);
      step();
    end
    idle_bus();
    @(negedge clk);
    chk({tag, "_ack_end"}, {31'b0, ACK}, 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] v [4];

    // Reset state
    idle_bus();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_ack", {31'b0, ACK}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_dat", DAT_R, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Classic write then read
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, "cw10");
    classic(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, "cr10");

    // Byte lanes
    classic(32'h20, 1'b1, 32'h11223344, 4'hF, 32'h0, "cw20");
    classic(32'h20, 1'b1, 32'h0000AA00, 4'b0010, 32'h0, "cw20b");
    classic(32'h20, 1'b0, 32'h0, 4'hF, 32'h1122AA44, "cr20");

    // Linear burst write/read of words 16..19
    v = '{32'd0, 32'd1, 32'd2, 32'd3};
    burst(32'h40, BTE_LINEAR, 1'b1, 4, v, "bw40");
    burst(32'h40, BTE_LINEAR, 1'b0, 4, v, "br40");

    // Wrap4 from word 18: 18,19,16,17
    v = '{32'd2, 32'd3, 32'd0, 32'd1};
    burst(32'h48, BTE_WRAP4, 1'b0, 4, v, "bw4");

    // Decode error leaves memory untouched (0x1000 would alias word 0)
    classic(32'h0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, "cw0");
    ADR = 32'h1000; WE = 1'b1; DAT_W = 32'h00000BAD; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    @(negedge clk);
    chk("derr_idle", {31'b0, ERR}, 32'd0);
    step();
    @(negedge clk);
    chk("derr_err", {31'b0, ERR}, 32'd1);
    chk("derr_ack", {31'b0, ACK}, 32'd0);
    chk("derr_dat", DAT_R, 32'd0);
    step();
    idle_bus();
    @(negedge clk);
    chk("derr_after", {31'b0, ERR}, 32'd0);
    step();
    classic(32'h0, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, "cr0");

    // Linear burst over the top of memory wraps to word 0
    v = '{32'h11110000, 32'h22220000, 32'h0, 32'h0};
    burst(32'hFFC, BTE_LINEAR, 1'b1, 2, v, "bwtop");
    classic(32'hFFC, 1'b0, 32'h0, 4'hF, 32'h11110000, "crtop");
    classic(32'h0, 1'b0, 32'h0, 4'hF, 32'h22220000, "crwrap0");

    // Wait state: two cycles of STB=0 hold the burst address
    ADR = 32'h40; WE = 1'b0; BTE = BTE_LINEAR; CTI = CTI_INCR; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    step();
    @(negedge clk);
    chk("ws_ack0", {31'b0, ACK}, 32'd1);
    chk("ws_dat0", DAT_R, 32'd0);
    step();
    STB = 1'b0;
    @(negedge clk);
    chk("ws_wait1_ack", {31'b0, ACK}, 32'd0);
    chk("ws_wait1_dat", DAT_R, 32'd0);
    step();
    @(negedge clk);
    chk("ws_wait2_ack", {31'b0, ACK}, 32'd0);
    step();
    STB = 1'b1; CTI = CTI_EOB;
    @(negedge clk);
    chk("ws_ack1", {31'b0, ACK}, 32'd1);
    chk("ws_dat1", DAT_R, 32'd1);
    step();
    idle_bus();
    @(negedge clk);
    chk("ws_end", {31'b0, ACK}, 32'd0);
    step();

    // Abort: CYC drop mid-burst writes nothing
    ADR = 32'h40; WE = 1'b1; BTE = BTE_LINEAR; CTI = CTI_INCR; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    step();
    DAT_W = 32'h000000A0;
    @(negedge clk);
    chk("ab_ack0", {31'b0, ACK}, 32'd1);
    step();
    CYC = 1'b0; DAT_W = 32'h000000BB;
    @(negedge clk);
    chk("ab_ack_drop", {31'b0, ACK}, 32'd0);
    step();
    idle_bus();
    step();
    classic(32'h44, 1'b0, 32'h0, 4'hF, 32'd1, "ab_rd17");
    classic(32'h40, 1'b0, 32'h0, 4'hF, 32'h000000A0, "ab_rd16");

    // Reset during CLASSIC clears outputs at once and commits no write
    ADR = 32'h20; WE = 1'b1; DAT_W = 32'h00000055; SEL = 4'hF; CTI = CTI_CLASSIC;
    CYC = 1'b1; STB = 1'b1;
    step();
    @(negedge clk);
    chk("rc_ack", {31'b0, ACK}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rc_ack_rst", {31'b0, ACK}, 32'd0);
    chk("rc_err_rst", {31'b0, ERR}, 32'd0);
    chk("rc_dat_rst", DAT_R, 32'd0);
    step();
    idle_bus();
    step();
    rst = 1'b0;
    step();
    classic(32'h20, 1'b0, 32'h0, 4'hF, 32'h1122AA44, "rc_rd20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
